pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_target_gen.sv | 54 +++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice.
//   - redir_type encodings (branch / jump / jump-register / reserved)
//   - two-state sequencer FSM enum
//   - default reset and exception vectors
//   - helper that qualifies a control-transfer request
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RT_BR   = 2'b00,
    RT_J    = 2'b01,
    RT_JR   = 2'b10,
    RT_NONE = 2'b11
  } redir_type_e;

  typedef enum logic {
    ST_SEQ   = 1'b0,
    ST_DELAY = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

  // The reserved encoding behaves exactly like no request at all.
  function automatic logic redir_req(input logic valid, input logic [1:0] rtype);
    return valid && (rtype != RT_NONE);
  endfunction

endpackage

// File: rtl/pc_sequencer_target_gen.sv
// pc_target_gen: combinational control-transfer target formation.
// Ports:
//   pc_plus4    in  ADDR_W  address of the instruction after the current pc
//   redir_type  in  2       RT_BR / RT_J / RT_JR / RT_NONE
//   instr_index in  26      J-format target field
//   br_offset   in  16      signed branch word offset
//   jr_addr     in  ADDR_W  register target
//   target      out ADDR_W  formed target (pc_plus4 for RT_NONE, unused then)
// All arithmetic wraps modulo 2^ADDR_W.
module pc_target_gen
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [1:0]        redir_type,
  input  logic [25:0]       instr_index,
  input  logic [15:0]       br_offset,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] target
);

  logic signed [ADDR_W-1:0] br_disp;
  logic [ADDR_W-1:0]        br_tgt;
  logic [31:0]              pc4_ext;
  logic [31:0]              j_tgt32;
  logic [ADDR_W-1:0]        j_tgt;
  logic [ADDR_W-1:0]        jr_tgt;
  logic                     unused_jr_low;

  // Sign-extended word offset scaled to bytes.
  assign br_disp = signed'({{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00});
  assign br_tgt  = pc_plus4 + $unsigned(br_disp);

  // Jump keeps the 256 MB region of pc_plus4; formed at 32 bits so that
  // ADDR_W=28 (no region bits) falls out of the truncation naturally.
  assign pc4_ext = 32'(pc_plus4);
  assign j_tgt32 = {pc4_ext[31:28], instr_index, 2'b00};
  assign j_tgt   = j_tgt32[ADDR_W-1:0];

  assign jr_tgt        = {jr_addr[ADDR_W-1:2], 2'b00};
  assign unused_jr_low = ^jr_addr[1:0];

  always_comb begin
    target = pc_plus4;
    case (redir_type)
      RT_BR:   target = br_tgt;
      RT_J:    target = j_tgt;
      RT_JR:   target = jr_tgt;
      default: target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch address sequencer with optional
// MIPS-style branch delay slot.
// Ports:
//   clk          in  1       rising-edge clock
//   rst          in  1       asynchronous active-high reset
//   stall        in  1       hold pc, state and target register
//   exc          in  1       exception request (overrides stall and state)
//   redir_valid  in  1       control transfer for the instruction at pc
//   redir_type   in  2       00 branch, 01 jump, 10 jump-register, 11 none
//   instr_index  in  26      J-format target field
//   br_offset    in  16      signed branch word offset
//   jr_addr      in  ADDR_W  register target
//   pc           out ADDR_W  registered fetch address
//   pc_plus4     out ADDR_W  pc + 4 (combinational)
//   pending      out 1       a latched target waits behind the delay slot
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC    = DEF_EXC_VEC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc,
  input  logic              redir_valid,
  input  logic [1:0]        redir_type,
  input  logic [25:0]       instr_index,
  input  logic [15:0]       br_offset,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pending
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

  seq_state_e        state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic [ADDR_W-1:0] tgt_q, tgt_nx;
  logic [ADDR_W-1:0] target;
  logic              req;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign req      = redir_req(redir_valid, redir_type);

  pc_target_gen #(
    .ADDR_W(ADDR_W)
  ) u_target_gen (
    .pc_plus4    (pc_plus4),
    .redir_type  (redir_type),
    .instr_index (instr_index),
    .br_offset   (br_offset),
    .jr_addr     (jr_addr),
    .target      (target)
  );

  // State, pc and target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SEQ;
      pc_q  <= RST_PC;
      tgt_q <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      tgt_q <= tgt_nx;
    end
  end

  // Next-state: exc > stall > DELAY completion > new request > sequential.
  // A request seen while in DELAY sits in the delay slot and is dropped.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    tgt_nx   = tgt_q;
    if (exc) begin
      state_nx = ST_SEQ;
      pc_nx    = EXC_PC;
      tgt_nx   = '0;
    end else if (stall) begin
      state_nx = state;
    end else if (state == ST_DELAY) begin
      state_nx = ST_SEQ;
      pc_nx    = tgt_q;
    end else if (req) begin
      if (DELAY_SLOT) begin
        state_nx = ST_DELAY;
        pc_nx    = pc_plus4;
        tgt_nx   = target;
      end else begin
        pc_nx    = target;
      end
    end else begin
      pc_nx = pc_plus4;
    end
  end

  // Outputs
  always_comb begin
    pending = DELAY_SLOT && (state == ST_DELAY);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Two instances share clock and reset:
// dut_ds uses the delay slot, dut_im redirects immediately.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_stall, a_exc, a_rv;
  logic [1:0]  a_rt;
  logic [25:0] a_ii;
  logic [15:0] a_bo;
  logic [31:0] a_jr, a_pc, a_pc4;
  logic        a_pend;

  logic        b_stall, b_exc, b_rv;
  logic [1:0]  b_rt;
  logic [25:0] b_ii;
  logic [15:0] b_bo;
  logic [31:0] b_jr, b_pc, b_pc4;
  logic        b_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h0000_0180), .DELAY_SLOT(1'b1)
  ) dut_ds (
    .clk(clk), .rst(rst), .stall(a_stall), .exc(a_exc),
    .redir_valid(a_rv), .redir_type(a_rt), .instr_index(a_ii),
    .br_offset(a_bo), .jr_addr(a_jr), .pc(a_pc), .pc_plus4(a_pc4),
    .pending(a_pend)
  );

  pc_sequencer #(
    .ADDR_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h0000_0180), .DELAY_SLOT(1'b0)
  ) dut_im (
    .clk(clk), .rst(rst), .stall(b_stall), .exc(b_exc),
    .redir_valid(b_rv), .redir_type(b_rt), .instr_index(b_ii),
    .br_offset(b_bo), .jr_addr(b_jr), .pc(b_pc), .pc_plus4(b_pc4),
    .pending(b_pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    a_stall = 0; a_exc = 0; a_rv = 0; a_rt = RT_NONE; a_ii = '0; a_bo = '0; a_jr = '0;
    b_stall = 0; b_exc = 0; b_rv = 0; b_rt = RT_NONE; b_ii = '0; b_bo = '0; b_jr = '0;

    // Reset state
    #12;
    check("rst_pc_ds", a_pc, 32'h0);
    check("rst_pend_ds", {31'b0, a_pend}, 32'h0);
    check("rst_pc_im", b_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rel_pc", a_pc, 32'h0);
    check("rel_pc4", a_pc4, 32'h4);
    step(); check("seq1", a_pc, 32'h4);
    step(); check("seq2", a_pc, 32'h8);
    step(); check("seq3", a_pc, 32'hC);
    step(); check("seq4_im", b_pc, 32'h10);
    check("seq4_ds", a_pc, 32'h10);

    // Immediate backward branch at 0x10; JR to 0x0040_0000 on delay-slot DUT
    b_rv = 1; b_rt = RT_BR; b_bo = 16'hFFFC;
    a_rv = 1; a_rt = RT_JR; a_jr = 32'h0040_0000;
    step();
    check("br_back", b_pc, 32'h4);
    check("br_pend_im", {31'b0, b_pend}, 32'h0);
    check("jr_slot", a_pc, 32'h14);
    check("jr_pend", {31'b0, a_pend}, 32'h1);
    b_rv = 0; a_rv = 0;
    step();
    check("br_after", b_pc, 32'h8);
    check("jr_tgt", a_pc, 32'h0040_0000);
    check("jr_pend_off", {31'b0, a_pend}, 32'h0);

    // Delay-slot jump; a branch in the slot must lose to the latched target.
    // Immediate DUT: JR to the top of the address space for wrap.
    a_rv = 1; a_rt = RT_J; a_ii = 26'h0100040;
    b_rv = 1; b_rt = RT_JR; b_jr = 32'hFFFF_FFFC;
    step();
    check("j_slot", a_pc, 32'h0040_0004);
    check("j_pend", {31'b0, a_pend}, 32'h1);
    check("wrap_load", b_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", b_pc4, 32'h0);
    a_rt = RT_BR; a_bo = 16'h0010;
    b_rv = 0;
    step();
    check("j_tgt", a_pc, 32'h0040_0100);
    check("j_pend_off", {31'b0, a_pend}, 32'h0);
    check("wrap", b_pc, 32'h0);

    // Reserved type is no request; start JR to 0x200 on delay-slot DUT
    b_rv = 1; b_rt = RT_NONE; b_jr = 32'h0000_0800;
    a_rv = 1; a_rt = RT_JR; a_jr = 32'h0000_0200;
    step();
    check("rsvd", b_pc, 32'h4);
    check("st_slot", a_pc, 32'h0040_0104);
    b_rv = 0; a_rv = 0;

    // Stall while pending: pc holds on the slot address
    a_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold", a_pc, 32'h0040_0104);
      check("st_pend", {31'b0, a_pend}, 32'h1);
    end
    a_stall = 0;
    step();
    check("st_tgt", a_pc, 32'h200);
    check("st_pend_off", {31'b0, a_pend}, 32'h0);

    // Stall in SEQ does not sample the held request
    a_stall = 1; a_rv = 1; a_rt = RT_JR; a_jr = 32'h500;
    step();
    check("seqst_hold", a_pc, 32'h200);
    check("seqst_pend", {31'b0, a_pend}, 32'h0);
    a_stall = 0;
    step();
    check("seqst_slot", a_pc, 32'h204);
    a_rv = 0;
    step();
    check("seqst_tgt", a_pc, 32'h500);

    // Exception with stall while a target is pending
    a_rv = 1; a_rt = RT_JR; a_jr = 32'h300;
    step();
    check("exc_pre", {31'b0, a_pend}, 32'h1);
    a_rv = 0; a_stall = 1; a_exc = 1;
    step();
    check("exc_pc", a_pc, 32'h180);
    check("exc_pend", {31'b0, a_pend}, 32'h0);
    a_stall = 0; a_exc = 0;
    step(); check("exc_seq1", a_pc, 32'h184);
    step(); check("exc_seq2", a_pc, 32'h188);

    // Exception beats a simultaneous request
    a_exc = 1; a_rv = 1; a_rt = RT_JR; a_jr = 32'h700;
    step();
    check("exc_win", a_pc, 32'h180);
    check("exc_win_pend", {31'b0, a_pend}, 32'h0);
    a_exc = 0; a_rv = 0;
    step(); check("exc_lost", a_pc, 32'h184);

    // Asynchronous reset while pending
    a_rv = 1; a_rt = RT_JR; a_jr = 32'h800;
    step();
    check("rd_pend", {31'b0, a_pend}, 32'h1);
    a_rv = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_pc", a_pc, 32'h0);
    check("arst_pend", {31'b0, a_pend}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(); check("arst_seq1", a_pc, 32'h4);
    step(); check("arst_seq2", a_pc, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
